// File: rtl/main_memory.sv
// main_memory: word-addressed backing store behind the cache controller.
// Accepts one read or write at a time over a level-held mem_* request.
// Answers after a fixed LATENCY with a one-cycle mem_ready pulse.
// Keeps saturating counts of completed reads and writes.
module main_memory #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int BYTE_OFFSET = 2,
  parameter int MEM_WORDS   = 16384,
  parameter int LATENCY     = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int IDX_W  = ADDR_WIDTH - BYTE_OFFSET;
  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // The latency counter only ever holds values up to LATENCY-2.
  localparam int LAT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic [LAT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  op_wr_r;
  logic [DATA_WIDTH-1:0] mem_r [0:MEM_WORDS-1];
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  ready_r;
  logic                  busy_r;
  logic [CNT_WIDTH-1:0]  rd_count_r;
  logic [CNT_WIDTH-1:0]  wr_count_r;

  logic                  accept_s;
  logic                  enter_resp_s;
  logic [IDX_W-1:0]      cur_idx_s;
  logic [DATA_WIDTH-1:0] cur_data_s;
  logic                  cur_wr_s;
  logic                  in_range_s;
  logic [MEM_AW-1:0]     mem_idx_s;
  logic                  mem_we_s;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode: requests are only sampled in IDLE, never in BUSY/RESP.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_wen || mem_ren) begin
          accept_s   = 1'b1;
          state_nx_s = (LATENCY == 1) ? RESP : BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAT_W'(0)) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = BUSY;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Effective request: with LATENCY=1 the array is touched on the accepting
  // edge itself, so the live inputs are used in IDLE and latched ones after.
  always_comb begin
    cur_idx_s    = idx_r;
    cur_data_s   = wdata_r;
    cur_wr_s     = op_wr_r;
    enter_resp_s = 1'b0;
    if (state_r == IDLE) begin
      cur_idx_s  = mem_addr[ADDR_WIDTH-1:BYTE_OFFSET];
      cur_data_s = mem_data_in;
      cur_wr_s   = mem_wen;
    end else begin
      cur_idx_s  = idx_r;
      cur_data_s = wdata_r;
      cur_wr_s   = op_wr_r;
    end
    if ((state_nx_s == RESP) && (state_r != RESP)) begin
      enter_resp_s = 1'b1;
    end else begin
      enter_resp_s = 1'b0;
    end
    in_range_s = ({{(32-IDX_W){1'b0}}, cur_idx_s} < 32'(MEM_WORDS));
    mem_idx_s  = cur_idx_s[MEM_AW-1:0];
    mem_we_s   = enter_resp_s && cur_wr_s && in_range_s && !rst;
  end

  // Storage array: not reset; written only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= cur_data_s;
    end
  end

  // Request latch, latency countdown, read data, handshake and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= LAT_W'(0);
      idx_r      <= IDX_W'(0);
      wdata_r    <= DATA_WIDTH'(0);
      op_wr_r    <= 1'b0;
      data_out_r <= DATA_WIDTH'(0);
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      rd_count_r <= CNT_WIDTH'(0);
      wr_count_r <= CNT_WIDTH'(0);
    end else begin
      if (accept_s) begin
        idx_r   <= mem_addr[ADDR_WIDTH-1:BYTE_OFFSET];
        wdata_r <= mem_data_in;
        op_wr_r <= mem_wen;
        cnt_r   <= LAT_W'(LATENCY - 2);
      end else if ((state_r == BUSY) && (cnt_r != LAT_W'(0))) begin
        cnt_r <= cnt_r - LAT_W'(1);
      end
      if (enter_resp_s && !cur_wr_s) begin
        data_out_r <= in_range_s ? mem_r[mem_idx_s] : DATA_WIDTH'(0);
      end
      if (enter_resp_s && cur_wr_s && (wr_count_r != {CNT_WIDTH{1'b1}})) begin
        wr_count_r <= wr_count_r + CNT_WIDTH'(1);
      end
      if (enter_resp_s && !cur_wr_s && (rd_count_r != {CNT_WIDTH{1'b1}})) begin
        rd_count_r <= rd_count_r + CNT_WIDTH'(1);
      end
      ready_r <= (state_nx_s == RESP);
      busy_r  <= (state_nx_s == BUSY) || (state_nx_s == RESP);
    end
  end

  assign mem_data_out = data_out_r;
  assign mem_ready    = ready_r;
  assign mem_busy     = busy_r;
  assign rd_count     = rd_count_r;
  assign wr_count     = wr_count_r;

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed checks of main_memory.
// dut0 runs with LATENCY=3 and the full array.
// dut1 runs with LATENCY=1, a 16-word array and 2-bit counters, which covers
// out-of-range accesses and counter saturation.
module tb_main_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr0, addr1;
  logic [31:0] din0, din1;
  logic        ren0, wen0, ren1, wen1;
  logic [31:0] dout0, dout1;
  logic        rdy0, rdy1, busy0, busy1;
  logic [15:0] rdc0, wrc0;
  logic [1:0]  rdc1, wrc1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  main_memory #(.LATENCY(3)) dut0 (
    .clk(clk), .rst(rst), .mem_addr(addr0), .mem_data_in(din0),
    .mem_ren(ren0), .mem_wen(wen0), .mem_data_out(dout0),
    .mem_ready(rdy0), .mem_busy(busy0), .rd_count(rdc0), .wr_count(wrc0)
  );

  main_memory #(.LATENCY(1), .MEM_WORDS(16), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .mem_addr(addr1), .mem_data_in(din1),
    .mem_ren(ren1), .mem_wen(wen1), .mem_data_out(dout1),
    .mem_ready(rdy1), .mem_busy(busy1), .rd_count(rdc1), .wr_count(wrc1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ren0 = 1'b0; wen0 = 1'b0; addr0 = 16'h0; din0 = 32'h0;
    ren1 = 1'b0; wen1 = 1'b0; addr1 = 16'h0; din1 = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Hold the request until mem_ready, keep it through the RESP cycle, then drop.
  // lat = cycles from driving the request to seeing mem_ready (20 = timeout).
  task automatic access(input bit sel, input bit w, input bit r,
                        input logic [15:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] q, output logic extra);
    if (sel) begin
      addr1 = a; din1 = d; wen1 = w; ren1 = r;
    end else begin
      addr0 = a; din0 = d; wen0 = w; ren0 = r;
    end
    lat = 20;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (sel ? rdy1 : rdy0) begin
        lat = i;
        break;
      end
    end
    q = sel ? dout1 : dout0;
    tick();
    extra = sel ? rdy1 : rdy0;
    if (sel) begin
      wen1 = 1'b0; ren1 = 1'b0;
    end else begin
      wen0 = 1'b0; ren0 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          pulses;
    logic [31:0] q;
    logic        extra;

    do_reset();
    check("rst_ready",  rdy0,  1'b0);
    check("rst_busy",   busy0, 1'b0);
    check("rst_dout",   dout0, 32'h0);
    check("rst_rdc",    rdc0,  16'h0);
    check("rst_wrc",    wrc0,  16'h0);
    check("rst_dout1",  dout1, 32'h0);

    // Write then immediate fill of the same word (write-back -> fill).
    access(1'b0, 1'b1, 1'b0, 16'h0040, 32'hDEADBEEF, lat, q, extra);
    check("t1_wr_lat",   lat,   3);
    check("t1_wr_once",  extra, 1'b0);
    access(1'b0, 1'b0, 1'b1, 16'h0040, 32'h0, lat, q, extra);
    check("t1_rd_lat",   lat,   3);
    check("t1_rd_data",  q,     32'hDEADBEEF);
    check("t1_wrc",      wrc0,  16'd1);
    check("t1_rdc",      rdc0,  16'd1);

    // ren held through mem_ready and the RESP cycle: only one accept.
    do_reset();
    addr0 = 16'h0040; ren0 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rdy0) pulses++;
    end
    ren0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rdy0) pulses++;
    end
    check("t2_pulses", pulses, 1);
    check("t2_rdc",    rdc0,   16'd1);
    check("t2_idle",   busy0,  1'b0);

    // Simultaneous ren and wen resolves as a write.
    do_reset();
    access(1'b0, 1'b1, 1'b1, 16'h0010, 32'h5, lat, q, extra);
    check("t4_lat", lat,  3);
    check("t4_wrc", wrc0, 16'd1);
    check("t4_rdc", rdc0, 16'd0);
    access(1'b0, 1'b0, 1'b1, 16'h0010, 32'h0, lat, q, extra);
    check("t4_data", q, 32'h5);

    // Reset one cycle after a write is sampled aborts it.
    access(1'b0, 1'b1, 1'b0, 16'h0080, 32'h1111, lat, q, extra);
    addr0 = 16'h0080; din0 = 32'h2222; wen0 = 1'b1;
    tick();
    check("t5_busy", busy0, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_busy_rst", busy0, 1'b0);
    tick();
    wen0 = 1'b0;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rdy0) pulses++;
    end
    check("t5_no_ready", pulses, 0);
    check("t5_wrc",      wrc0,   16'd0);
    access(1'b0, 1'b0, 1'b1, 16'h0080, 32'h0, lat, q, extra);
    check("t5_old_data", q, 32'h1111);

    // LATENCY=1 instance: timing, out-of-range, saturation, data hold.
    do_reset();
    access(1'b1, 1'b1, 1'b0, 16'h0000, 32'h99, lat, q, extra);
    check("t6_wr_lat",  lat,   1);
    check("t6_wr_once", extra, 1'b0);
    access(1'b1, 1'b1, 1'b0, 16'h0040, 32'h77, lat, q, extra);
    check("t6_oor_wr_lat", lat, 1);
    access(1'b1, 1'b0, 1'b1, 16'h0000, 32'h0, lat, q, extra);
    check("t6_no_alias", q, 32'h99);
    access(1'b1, 1'b0, 1'b1, 16'h0040, 32'h0, lat, q, extra);
    check("t6_oor_rd_lat",  lat, 1);
    check("t6_oor_rd_data", q,   32'h0);
    check("t6_wrc", wrc1, 2'd2);
    check("t6_rdc", rdc1, 2'd2);
    access(1'b1, 1'b1, 1'b0, 16'h0004, 32'hABCD, lat, q, extra);
    access(1'b1, 1'b0, 1'b1, 16'h0004, 32'h0, lat, q, extra);
    check("t6_rd_data", q, 32'hABCD);
    access(1'b1, 1'b1, 1'b0, 16'h0008, 32'h1, lat, q, extra);
    check("t6_dout_hold", dout1, 32'hABCD);
    check("t6_wrc_sat",   wrc1,  2'd3);
    access(1'b1, 1'b0, 1'b1, 16'h0008, 32'h0, lat, q, extra);
    check("t6_rd_data2",  q,    32'h1);
    check("t6_rdc_sat",   rdc1, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
